// File: rtl/gray_decoder.sv
// Gray-count receiver: converts a sampled Gray count to binary and reports step, wrap and
// illegal multi-bit transitions. Define GRAY_DECODER_SYNC_EN to add a 2-flop input synchronizer.
module gray_decoder #(
    parameter int W  = 4,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ce,
    input  logic          clr,
    input  logic [W-1:0]  gray_in,
    output logic [W-1:0]  bin,
    output logic          valid,
    output logic [W-1:0]  delta,
    output logic          wrap,
    output logic          err,
    output logic [CW-1:0] err_cnt
);

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    function automatic logic [W-1:0] gray2bin(input logic [W-1:0] g);
        logic [W-1:0] b;
        b[W-1] = g[W-1];
        for (int i = W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // True when more than one bit is set: clearing the lowest set bit leaves something behind.
    function automatic logic multi_bit(input logic [W-1:0] x);
        return (x & (x - W'(1))) != '0;
    endfunction

    logic [W-1:0] w_g_in;
    logic         w_ce_in;

`ifdef GRAY_DECODER_SYNC_EN
    logic [W-1:0] r_sync1;
    logic [W-1:0] r_sync2;
    logic         r_ce_d1;
    logic         r_ce_d2;

    // Synchronizer stages; the enable rides alongside so it lines up with the settled data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_ce_d1 <= 1'b0;
            r_ce_d2 <= 1'b0;
        end else begin
            r_sync1 <= gray_in;
            r_sync2 <= r_sync1;
            if (clr) begin
                r_ce_d1 <= 1'b0;
                r_ce_d2 <= 1'b0;
            end else begin
                r_ce_d1 <= ce;
                r_ce_d2 <= r_ce_d1;
            end
        end
    end

    assign w_g_in  = r_sync2;
    assign w_ce_in = r_ce_d2;
`else
    assign w_g_in  = gray_in;
    assign w_ce_in = ce;
`endif

    logic [W-1:0] r_g_p0;
    logic         r_vld_p0;
    logic [0:0]   r_state;

    // Stage 1: capture the Gray sample
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_g_p0   <= '0;
            r_vld_p0 <= 1'b0;
        end else if (clr) begin
            r_vld_p0 <= 1'b0;
        end else begin
            r_vld_p0 <= w_ce_in;
            if (w_ce_in) begin
                r_g_p0 <= w_g_in;
            end
        end
    end

    logic [W-1:0] w_b_new;
    logic [W-1:0] w_g_prev;
    logic [W-1:0] w_delta;
    logic         w_wrap;
    logic         w_err;

    assign w_b_new  = gray2bin(r_g_p0);
    assign w_g_prev = bin ^ (bin >> 1);
    assign w_delta  = w_b_new - bin;
    assign w_wrap   = (bin == '1) && (w_b_new == '0);
    assign w_err    = multi_bit(w_g_prev ^ r_g_p0);

    // Stage 2: decode and compare against the previous accepted sample
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin     <= '0;
            valid   <= 1'b0;
            delta   <= '0;
            wrap    <= 1'b0;
            err     <= 1'b0;
            err_cnt <= '0;
            r_state <= ST_INIT;
        end else if (clr) begin
            valid   <= 1'b0;
            err_cnt <= '0;
            r_state <= ST_INIT;
        end else if (r_vld_p0) begin
            valid <= 1'b1;
            bin   <= w_b_new;
            if (r_state == ST_INIT) begin
                delta   <= '0;
                wrap    <= 1'b0;
                err     <= 1'b0;
                r_state <= ST_RUN;
            end else begin
                delta <= w_delta;
                wrap  <= w_wrap;
                err   <= w_err;
                if (w_err && (err_cnt != '1)) begin
                    err_cnt <= err_cnt + CW'(1);
                end
            end
        end else begin
            valid <= 1'b0;
        end
    end

endmodule
